// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_arbiter_pkg
//   Shared constants and types for the frame-buffer arbiter: display geometry,
//   pixel and address widths, write-FIFO sizing, the drain FSM state type and
//   the {addr,data} payload carried by the write FIFO.
package vga_fb_arbiter_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int PIX_W       = 24;
  localparam int FB_ADDR_W   = 19;
  localparam int WFIFO_DEPTH = 4;

  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int WF_PTR_W = $clog2(WFIFO_DEPTH);
  localparam int WF_CNT_W = WF_PTR_W + 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } fb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } wfifo_entry_t;

  // True when a word address lies inside the visible frame.
  function automatic logic addr_in_frame(input logic [FB_ADDR_W-1:0] addr);
    return addr < FB_ADDR_W'(FB_WORDS);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if
//   Bundles the display read port, producer write port, drain handshake and
//   the frame-buffer RAM port of the arbiter.
//   slave  : the arbiter's view (takes requests, drives the RAM)
//   master : the environment's view (requesters and the RAM)
interface vga_fb_arbiter_if;
  import vga_fb_arbiter_pkg::*;

  logic                 disp_req;
  logic [FB_ADDR_W-1:0] disp_addr;
  logic                 disp_rvalid;
  logic [PIX_W-1:0]     disp_data;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]     wr_data;

  logic                 drain_req;
  logic                 drain_done;
  logic                 oob_err;

  logic                 mem_en;
  logic                 mem_we;
  logic [FB_ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]     mem_wdata;
  logic [PIX_W-1:0]     mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, drain_req, mem_rdata,
    output disp_rvalid, disp_data, wr_ready, drain_done, oob_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, drain_req, mem_rdata,
    input  disp_rvalid, disp_data, wr_ready, drain_done, oob_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_fb_arbiter_wfifo.sv
// vga_fb_arbiter_wfifo
//   Small synchronous FIFO holding pending pixel writes ({addr,data}).
//   Ports: clk, rst_n (async active-low), push/push_entry, pop, head (entry at
//   the read pointer), full, empty, count (occupancy 0..WFIFO_DEPTH).
//   Push while full and pop while empty are ignored. Push and pop in the same
//   cycle leave the count unchanged.
module vga_fb_arbiter_wfifo
  import vga_fb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  wfifo_entry_t        push_entry,
  input  logic                pop,
  output wfifo_entry_t        head,
  output logic                full,
  output logic                empty,
  output logic [WF_CNT_W-1:0] count
);

  wfifo_entry_t        storage_q [WFIFO_DEPTH];
  logic [WF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WF_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full  = (count_q == WF_CNT_W'(WFIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = storage_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + WF_PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + WF_PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + WF_CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - WF_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) storage_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares a single-port, 1-cycle-read frame-buffer RAM between VGA scan-out
//   reads and producer pixel writes. Display reads always win; writes wait in
//   a small FIFO and retire in cycles without a display read.
//   Ports: clk (pixel clock), rst_n (async active-low), bus (slave modport:
//   display read port, write port, drain handshake, oob_err, RAM port).
//   Read latency is fixed at two cycles: request sampled at edge k, RAM
//   command in cycle k+1, disp_rvalid/disp_data in cycle k+2.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  vga_fb_arbiter_if.slave bus
);

  fb_state_t            state_q, state_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                 disp_rvalid_q, disp_rvalid_d;
  logic                 oob_err_q, oob_err_d;

  logic                 wr_ready;
  logic                 wr_accept;
  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [WF_CNT_W-1:0]  fifo_count;
  wfifo_entry_t         fifo_in, fifo_head;

  assign wr_ready  = !fifo_full && (state_q == RUN);
  assign wr_accept = bus.wr_valid && wr_ready;
  // Out-of-frame writes complete the handshake but are never queued.
  assign fifo_push = wr_accept && addr_in_frame(bus.wr_addr);
  assign fifo_in   = '{addr: bus.wr_addr, data: bus.wr_data};

  vga_fb_arbiter_wfifo u_wfifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // RAM command for next cycle. The pop only sees entries pushed at earlier
  // edges, so a fresh write cannot bypass the FIFO. Address and write data
  // hold their last value while the RAM is idle.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fifo_pop    = 1'b0;
    if (bus.disp_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = bus.disp_addr;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_head.addr;
      mem_wdata_d = fifo_head.data;
    end
  end

  // Read data arrives the cycle after a read command is on the RAM port.
  always_comb begin
    disp_rvalid_d = mem_en_q && !mem_we_q;
    oob_err_d     = oob_err_q || (wr_accept && !addr_in_frame(bus.wr_addr));
  end

  // Drain completes once the FIFO is empty: by then the last popped write is
  // already on the RAM port, so DONE follows it by one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.drain_req) state_d = DRAIN;
      DRAIN:   if (fifo_count == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      disp_rvalid_q <= 1'b0;
      oob_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      disp_rvalid_q <= disp_rvalid_d;
      oob_err_q     <= oob_err_d;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.disp_data   = bus.mem_rdata;
  assign bus.oob_err     = oob_err_q;
  assign bus.drain_done  = (state_q == DONE);

endmodule
